// File: rtl/c1126_seq_ctrl.sv
// c1126_seq_ctrl: run controller for the c1126 core.
// Holds a 3-bit vector table, pulses the core reset, plays one vector per
// clock, captures each O0..O2 response after the core latency, then pulses done.
// Optional feature macro: C1126_SEQ_MISR_EN (8-bit response MISR on sig).
// Handshake: start is a single-cycle request honoured only in IDLE; busy is
// high from the first cycle after an accepted start through the final
// cap_valid cycle; done is a one-cycle pulse after that, with busy low.
module c1126_seq_ctrl #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int RST_CYC = 2,
    parameter int CAP_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [2:0]    cfg_data,
    input  logic [AW:0]   len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          dut_rst,
    output logic [2:0]    dut_in,
    input  logic [2:0]    dut_out,
    output logic          cap_valid,
    output logic [AW-1:0] cap_idx,
    output logic [2:0]    cap_data,
    output logic [7:0]    sig,
    output logic [2:0]    dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RSTP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int          RW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_N   = (AW + 1)'(1);

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [AW:0]   k_q, k_d;
    logic [AW:0]   n_q, n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dut_rst_q, dut_rst_d;
    logic [2:0]    dut_in_q, dut_in_d;
    logic          drv_v_q, drv_v_d;
    logic [AW-1:0] drv_idx_q, drv_idx_d;
    logic          tbl_we;
    logic [AW:0]   n_clamp;

    logic [2:0]    tbl_q [DEPTH];
    logic          pv_q [CAP_LAT];
    logic [AW-1:0] pidx_q [CAP_LAT];
    logic          cap_valid_q;
    logic [AW-1:0] cap_idx_q;
    logic [2:0]    cap_data_q;

    assign n_clamp = (len > DEPTH_L) ? DEPTH_L : len;

    // Sequencing FSM: next state, drive vector, drive-valid tag and busy/done.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        k_d       = k_q;
        n_d       = n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dut_rst_d = 1'b0;
        dut_in_d  = 3'b000;
        drv_v_d   = 1'b0;
        drv_idx_d = '0;
        tbl_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tbl_we = cfg_we;
                if (start) begin
                    n_d = n_clamp;
                    if (n_clamp == '0) begin
                        // Empty run: skip straight to the done pulse.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_RSTP;
                        busy_d    = 1'b1;
                        dut_rst_d = 1'b1;
                        rcnt_d    = '0;
                    end
                end
            end
            S_RSTP: begin
                if (rcnt_q == RW'(RST_CYC - 1)) begin
                    state_d   = S_RUN;
                    dut_in_d  = tbl_q[0];
                    drv_v_d   = 1'b1;
                    drv_idx_d = '0;
                    k_d       = ONE_N;
                end else begin
                    rcnt_d    = rcnt_q + 1'b1;
                    dut_rst_d = 1'b1;
                end
            end
            S_RUN: begin
                if (k_q == n_q) begin
                    state_d = S_DRAIN;
                end else begin
                    dut_in_d  = tbl_q[k_q[AW-1:0]];
                    drv_v_d   = 1'b1;
                    drv_idx_d = k_q[AW-1:0];
                    k_d       = k_q + ONE_N;
                end
            end
            S_DRAIN: begin
                if (cap_valid_q && ({1'b0, cap_idx_q} == n_q - ONE_N)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control registers; reset holds the core in reset and aborts any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rcnt_q    <= '0;
            k_q       <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dut_rst_q <= 1'b1;
            dut_in_q  <= 3'b000;
            drv_v_q   <= 1'b0;
            drv_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            k_q       <= k_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dut_rst_q <= dut_rst_d;
            dut_in_q  <= dut_in_d;
            drv_v_q   <= drv_v_d;
            drv_idx_q <= drv_idx_d;
        end
    end

    // Vector table: written only while idle, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= 3'b000;
        end else if (tbl_we) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    // Latency pipe: the drive tag reaches the last stage in the cycle the
    // core response for that vector is valid, which is then sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CAP_LAT; i++) begin
                pv_q[i]   <= 1'b0;
                pidx_q[i] <= '0;
            end
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_data_q  <= 3'b000;
        end else begin
            pv_q[0]   <= drv_v_q;
            pidx_q[0] <= drv_idx_q;
            for (int i = 1; i < CAP_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
            cap_valid_q <= pv_q[CAP_LAT-1];
            if (pv_q[CAP_LAT-1]) begin
                cap_idx_q  <= pidx_q[CAP_LAT-1];
                cap_data_q <= dut_out;
            end
        end
    end

`ifdef C1126_SEQ_MISR_EN
    logic [7:0] sig_q, sig_d;

    // One MISR step, polynomial x^8+x^6+x^5+x^4+1, response folded into [2:0].
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [2:0] d);
        misr_step = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00) ^ {5'b00000, d};
    endfunction

    // Signature next value: cleared on an accepted start, stepped per capture.
    always_comb begin
        sig_d = sig_q;
        if (cap_valid_q) sig_d = misr_step(sig_q, cap_data_q);
        if (state_q == S_IDLE && start) sig_d = 8'h00;
    end

    // Signature register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 8'h00;
        else     sig_q <= sig_d;
    end

    assign sig = sig_q;
`else
    assign sig = 8'h00;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign dut_rst     = dut_rst_q;
    assign dut_in      = dut_in_q;
    assign cap_valid   = cap_valid_q;
    assign cap_idx     = cap_idx_q;
    assign cap_data    = cap_data_q;
    assign dbg_state_o = state_q;

endmodule
